// File: rtl/ssm_funnel_shifter.sv
// Bit funnel: buffers MSB-first input words and exposes the next unconsumed bits
// as a window that can be consumed in variable-length chunks or byte-aligned.
module ssm_funnel_shifter #(
    parameter  int DW     = 128,
    parameter  int SE_MAX = 128,
    parameter  int CNT_W  = 32,
    localparam int CAP    = 2 * DW,
    localparam int FW     = $clog2(CAP + 1),
    localparam int CBW    = $clog2(SE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DW-1:0]     in_data_i,
    input  logic              in_last_i,
    output logic [SE_MAX-1:0] win_data_o,
    output logic              win_valid_o,
    input  logic              cons_en_i,
    input  logic [CBW-1:0]    cons_bits_i,
    input  logic              align_en_i,
    output logic [FW-1:0]     fullness_o,
    output logic [CNT_W-1:0]  bits_used_o,
    output logic              err_o
);

    localparam logic [FW-1:0] CapMinusDw = FW'(CAP - DW);
    localparam logic [FW-1:0] SeMaxF     = FW'(SE_MAX);
    localparam logic [FW-1:0] DwF        = FW'(DW);

    // Valid bits sit MSB-aligned in shiftReg_q; everything below fullness is kept zero.
    logic [CAP-1:0]   shiftReg_q, shiftReg_d;
    logic [FW-1:0]    fullness_q, fullness_d;
    logic [CNT_W-1:0] bitsUsed_q, bitsUsed_d;
    logic             eos_q;
    logic             err_q;

    logic             winValid;
    logic             accept;
    logic             setErr;
    logic [FW-1:0]    consExt;
    logic [FW-1:0]    consLimit;
    logic [2:0]       pad;
    logic [FW-1:0]    padExt;
    logic [FW-1:0]    removed;
    logic [FW-1:0]    postFull;
    logic [CAP-1:0]   shifted;
    logic [CAP-1:0]   appended;
    logic [SE_MAX-1:0] winMask;

    assign winValid  = (fullness_q >= SeMaxF) || (eos_q && (fullness_q != '0));
    assign consExt   = FW'(cons_bits_i);
    assign consLimit = (fullness_q < SeMaxF) ? fullness_q : SeMaxF;
    // Distance to the next byte boundary of the consumed count, i.e. (8 - used) mod 8.
    assign pad       = 3'd0 - bitsUsed_q[2:0];
    assign padExt    = FW'(pad);

    always_comb begin
        removed = '0;
        setErr  = 1'b0;
        if (cons_en_i && align_en_i) begin
            setErr = 1'b1;
        end else if (cons_en_i) begin
            if (winValid && (consExt <= consLimit)) begin
                removed = consExt;
            end else begin
                setErr = 1'b1;
            end
        end else if (align_en_i) begin
            if (fullness_q >= padExt) begin
                removed = padExt;
            end else begin
                setErr = 1'b1;
            end
        end
    end

    // The new word lands right behind whatever survives this cycle's removal.
    assign accept     = in_valid_i && in_ready_o;
    assign postFull   = fullness_q - removed;
    assign shifted    = shiftReg_q << removed;
    assign appended   = {in_data_i, {DW{1'b0}}} >> postFull;
    assign shiftReg_d = accept ? (shifted | appended) : shifted;
    assign fullness_d = postFull + (accept ? DwF : {FW{1'b0}});
    assign bitsUsed_d = bitsUsed_q + CNT_W'(removed);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shiftReg_q <= '0;
            fullness_q <= '0;
            bitsUsed_q <= '0;
            eos_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (start_i) begin
            shiftReg_q <= '0;
            fullness_q <= '0;
            bitsUsed_q <= '0;
            eos_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            shiftReg_q <= shiftReg_d;
            fullness_q <= fullness_d;
            bitsUsed_q <= bitsUsed_d;
            eos_q      <= eos_q | (accept && in_last_i);
            err_q      <= err_q | setErr;
        end
    end

    // Top 'fullness' window bits pass through; the rest read as zero.
    assign winMask     = ~({SE_MAX{1'b1}} >> fullness_q);
    assign win_data_o  = shiftReg_q[CAP-1 -: SE_MAX] & winMask;
    assign win_valid_o = winValid;
    assign in_ready_o  = (fullness_q <= CapMinusDw) && !eos_q;
    assign fullness_o  = fullness_q;
    assign bits_used_o = bitsUsed_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ssm_funnel_shifter.sv
// Scoreboard bench for ssm_funnel_shifter: a bit-queue model predicts the state after
// every edge, and an independent monitor compares the DUT against those predictions.
module tb_ssm_funnel_shifter;

    localparam int DW     = 128;
    localparam int SE_MAX = 128;
    localparam int CNT_W  = 32;
    localparam int CAP    = 2 * DW;
    localparam int FW     = $clog2(CAP + 1);
    localparam int CBW    = $clog2(SE_MAX + 1);

    logic              clk;
    logic              rstn;
    logic              start;
    logic              inValid;
    logic              inReady;
    logic [DW-1:0]     inData;
    logic              inLast;
    logic [SE_MAX-1:0] winData;
    logic              winValid;
    logic              consEn;
    logic [CBW-1:0]    consBits;
    logic              alignEn;
    logic [FW-1:0]     fullness;
    logic [CNT_W-1:0]  bitsUsed;
    logic              err;

    ssm_funnel_shifter dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start),
        .in_valid_i (inValid),
        .in_ready_o (inReady),
        .in_data_i  (inData),
        .in_last_i  (inLast),
        .win_data_o (winData),
        .win_valid_o(winValid),
        .cons_en_i  (consEn),
        .cons_bits_i(consBits),
        .align_en_i (alignEn),
        .fullness_o (fullness),
        .bits_used_o(bitsUsed),
        .err_o      (err)
    );

    typedef struct {
        logic [SE_MAX-1:0] win;
        logic              wv;
        logic [FW-1:0]     full;
        logic [CNT_W-1:0]  used;
        logic              err;
        logic              rdy;
    } expT;

    expT         expQ[$];
    bit          mq[$];
    bit [31:0]   mUsed;
    bit          mEos;
    bit          mErr;
    int          checkCount;
    int          failCount;
    int          cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pushExpected();
        expT e;
        int unsigned sz;
        sz    = mq.size();
        e.win = '0;
        for (int i = 0; i < SE_MAX; i++) begin
            if (i < sz) e.win[SE_MAX-1-i] = mq[i];
        end
        e.wv   = (sz >= SE_MAX) || (mEos && sz > 0);
        e.full = FW'(sz);
        e.used = mUsed;
        e.err  = mErr;
        e.rdy  = (sz <= CAP - DW) && !mEos;
        expQ.push_back(e);
    endtask

    // The stream is a plain queue of bits: consuming pops the front, accepting appends.
    task automatic modelStep(input bit st, input bit vld, input logic [DW-1:0] data, input bit last,
                             input bit ce, input int unsigned cb, input bit ae);
        int unsigned sz, lim, rm, pad;
        bit rdy, wv;
        sz  = mq.size();
        rdy = (sz <= CAP - DW) && !mEos;
        wv  = (sz >= SE_MAX) || (mEos && sz > 0);
        lim = (sz < SE_MAX) ? sz : SE_MAX;
        pad = (8 - (mUsed % 8)) % 8;
        rm  = 0;
        if (st) begin
            mq.delete();
            mUsed = 0;
            mEos  = 0;
            mErr  = 0;
        end else begin
            if (ce && ae) mErr = 1;
            else if (ce) begin
                if (wv && cb <= lim) rm = cb;
                else mErr = 1;
            end else if (ae) begin
                if (sz >= pad) rm = pad;
                else mErr = 1;
            end
            for (int unsigned i = 0; i < rm; i++) void'(mq.pop_front());
            mUsed = mUsed + rm;
            if (vld && rdy) begin
                for (int i = DW - 1; i >= 0; i--) mq.push_back(data[i]);
                if (last) mEos = 1;
            end
        end
        pushExpected();
    endtask

    // Called at 2 time units after an edge; returns 2 units after the following edge.
    task automatic applyStimulus(input bit st, input bit vld, input logic [DW-1:0] data, input bit last,
                                 input bit ce, input int unsigned cb, input bit ae);
        start    = st;
        inValid  = vld;
        inData   = data;
        inLast   = last;
        consEn   = ce;
        consBits = CBW'(cb);
        alignEn  = ae;
        modelStep(st, vld, data, last, ce, cb, ae);
        @(posedge clk);
        #2;
        start   = 1'b0;
        inValid = 1'b0;
        inLast  = 1'b0;
        consEn  = 1'b0;
        alignEn = 1'b0;
    endtask

    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput($sformatf("cyc%0d_win_data", cyc), 128'(winData), 128'(e.win));
                checkOutput($sformatf("cyc%0d_win_valid", cyc), 128'(winValid), 128'(e.wv));
                checkOutput($sformatf("cyc%0d_fullness", cyc), 128'(fullness), 128'(e.full));
                checkOutput($sformatf("cyc%0d_bits_used", cyc), 128'(bitsUsed), 128'(e.used));
                checkOutput($sformatf("cyc%0d_err", cyc), 128'(err), 128'(e.err));
                checkOutput($sformatf("cyc%0d_in_ready", cyc), 128'(inReady), 128'(e.rdy));
            end
        end
    end

    initial begin
        logic [DW-1:0] w1, w2;
        logic [127:0]  winExp;
        int unsigned   sz, lim, cb;
        bit            st, vld, last, ce, ae;

        rstn     = 1'b0;
        start    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        consEn   = 1'b0;
        consBits = '0;
        alignEn  = 1'b0;
        mUsed    = 0;
        mEos     = 0;
        mErr     = 0;
        #3;
        checkOutput("rst_fullness", 128'(fullness), 128'd0);
        checkOutput("rst_bits_used", 128'(bitsUsed), 128'd0);
        checkOutput("rst_err", 128'(err), 128'd0);
        checkOutput("rst_win_valid", 128'(winValid), 128'd0);
        checkOutput("rst_win_data", 128'(winData), 128'd0);
        checkOutput("rst_in_ready", 128'(inReady), 128'd1);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;

        // Single word straight after reset, no start pulse.
        w1 = '0;
        w1[127:120] = 8'hF0;
        applyStimulus(0, 1, w1, 0, 0, 0, 0);
        checkOutput("one_word_win_valid", 128'(winValid), 128'd1);
        checkOutput("one_word_win_data", 128'(winData), 128'(w1));
        checkOutput("one_word_fullness", 128'(fullness), 128'd128);
        checkOutput("one_word_in_ready", 128'(inReady), 128'd1);

        // Consume 5 while accepting a second word.
        w2 = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(0, 1, w2, 0, 1, 5, 0);
        winExp = {w1[122:0], w2[127:123]};
        checkOutput("cons_acc_fullness", 128'(fullness), 128'd251);
        checkOutput("cons_acc_bits_used", 128'(bitsUsed), 128'd5);
        checkOutput("cons_acc_window", 128'(winData), winExp);

        // Last word, then drain it past the window threshold.
        applyStimulus(1, 0, '0, 0, 0, 0, 0);
        w1 = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(0, 1, w1, 1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 100, 0);
        checkOutput("eos_in_ready", 128'(inReady), 128'd0);
        checkOutput("eos_win_valid", 128'(winValid), 128'd1);
        checkOutput("eos_fullness", 128'(fullness), 128'd28);
        checkOutput("eos_low_zero", 128'(winData[99:0]), 128'd0);
        applyStimulus(0, 0, '0, 0, 1, 28, 0);
        checkOutput("eos_drain_fullness", 128'(fullness), 128'd0);
        checkOutput("eos_drain_win_valid", 128'(winValid), 128'd0);

        // Byte alignment from 13 consumed bits, then an oversized consume.
        applyStimulus(1, 0, '0, 0, 0, 0, 0);
        applyStimulus(0, 1, w1, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 13, 0);
        applyStimulus(0, 0, '0, 0, 0, 0, 1);
        checkOutput("align_bits_used", 128'(bitsUsed), 128'd16);
        checkOutput("align_fullness", 128'(fullness), 128'd112);
        applyStimulus(0, 0, '0, 0, 1, 200, 0);
        checkOutput("over_err", 128'(err), 128'd1);
        checkOutput("over_fullness", 128'(fullness), 128'd112);

        // Start wins over a simultaneous accept and consume.
        applyStimulus(1, 1, w2, 0, 1, 5, 0);
        checkOutput("start_fullness", 128'(fullness), 128'd0);
        checkOutput("start_bits_used", 128'(bitsUsed), 128'd0);
        checkOutput("start_err", 128'(err), 128'd0);

        // Asynchronous reset with a partly full buffer and err raised.
        applyStimulus(0, 1, w1, 0, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 200, 0);
        applyStimulus(0, 1, w2, 0, 1, 56, 0);
        checkOutput("pre_rst_fullness", 128'(fullness), 128'd200);
        checkOutput("pre_rst_err", 128'(err), 128'd1);
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_fullness", 128'(fullness), 128'd0);
        checkOutput("async_rst_bits_used", 128'(bitsUsed), 128'd0);
        checkOutput("async_rst_err", 128'(err), 128'd0);
        checkOutput("async_rst_win_valid", 128'(winValid), 128'd0);
        checkOutput("async_rst_win_data", 128'(winData), 128'd0);
        checkOutput("async_rst_in_ready", 128'(inReady), 128'd1);
        mq.delete();
        mUsed = 0;
        mEos  = 0;
        mErr  = 0;
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #2;

        // Randomised traffic against the bit-queue model.
        for (int n = 0; n < 3000; n++) begin
            sz   = mq.size();
            lim  = (sz < SE_MAX) ? sz : SE_MAX;
            st   = ($urandom_range(0, 99) == 0) || (mEos && sz == 0 && $urandom_range(0, 3) == 0);
            vld  = ($urandom_range(0, 3) != 0);
            last = ($urandom_range(0, 29) == 0);
            ce   = ($urandom_range(0, 1) == 1);
            ae   = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 9) == 0) cb = $urandom_range(0, 255);
            else cb = $urandom_range(0, lim);
            applyStimulus(st, vld, {$urandom, $urandom, $urandom, $urandom}, last, ce, cb, ae);
        end

        repeat (2) @(posedge clk);
        #2;
        checkOutput("queue_drained", 128'(expQ.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/ssm_funnel_shifter.md
SSM_FUNNEL_SHIFTER -- requirements
Module: ssm_funnel_shifter

Interface
REQ-001 The block SHALL have parameter DW, default 128, meaning the input word width in bits.
REQ-002 The block SHALL have parameter SE_MAX, default 128, meaning the maximum bits consumed per cycle; legal range 1..DW.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning the width of the consumed-bit counter.
REQ-004 The block SHALL define local CAP = 2*DW (buffer bits) and FW = clog2(CAP+1) (fullness width).
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  synchronous clear of buffer, counters and flags; begins a new slice.
REQ-008 in_valid  input  1  in_data holds a valid word.
REQ-009 in_ready  output  1  buffer can accept a word this cycle.
REQ-010 in_data  input  DW  input bitstream word, MSB first.
REQ-011 in_last  input  1  qualifies the final word of the slice.
REQ-012 win_data  output  SE_MAX  next unconsumed bits, MSB-aligned, zero-padded beyond fullness.
REQ-013 win_valid  output  1  window is usable.
REQ-014 cons_en  input  1  consume request.
REQ-015 cons_bits  input  clog2(SE_MAX+1)  bits to remove from the window head.
REQ-016 align_en  input  1  discard bits up to the next 8-bit boundary of the total consumed count.
REQ-017 fullness  output  FW  valid bits currently buffered.
REQ-018 bits_used  output  CNT_W  total bits consumed since start, wrapping modulo 2^CNT_W.
REQ-019 err  output  1  sticky illegal-consume flag.

Function
REQ-020 in_ready SHALL equal (fullness <= CAP-DW) and !eos, where eos is a registered flag set when a word with in_last is accepted; in_ready depends on registered state only.
REQ-021 A word SHALL be accepted when in_valid && in_ready; it is appended directly behind the valid bits (post-consume position on a simultaneous consume).
REQ-022 win_valid SHALL be (fullness >= SE_MAX) || (eos && fullness > 0).
REQ-023 win_data SHALL be combinational from the registered buffer: buffer bits [CAP-1 -: SE_MAX], with bit positions at or beyond fullness forced to 0.
REQ-024 A consume SHALL be legal when cons_en && win_valid && cons_bits <= min(SE_MAX, fullness); a legal consume left-shifts the buffer by cons_bits and adds cons_bits to bits_used in the same edge.
REQ-025 An illegal consume (cons_en with !win_valid, or cons_bits over the limit) SHALL be ignored and SHALL set err until start or reset.
REQ-026 align_en SHALL apply when cons_en is low, and only if fullness >= pad, where pad = (8 - bits_used[2:0]) mod 8; it removes pad bits and adds pad to bits_used; if fullness < pad, align is ignored and err is set; align_en together with cons_en SHALL set err and perform neither.
REQ-027 Next fullness SHALL be fullness - removed + (accept ? DW : 0); this result never exceeds CAP.
REQ-028 A simultaneous accept and consume SHALL both take effect in one cycle, with zero bubble.
REQ-029 start SHALL take priority over all other inputs: fullness, bits_used, eos, err and buffer are set to 0, and inputs in that cycle are ignored.
REQ-030 Latency: an accepted word SHALL appear in win_data on the next cycle.
REQ-031 cons_bits = 0 with cons_en SHALL be legal and a no-op.

Reset
REQ-032 While rstn is low, all registers SHALL be 0: fullness=0, bits_used=0, err=0, eos=0, win_valid=0, win_data=0, in_ready=1.
REQ-033 Reset deassertion mid-slice SHALL require no start pulse before the first accept.

Verification
REQ-034 After reset, accept one word 0xF0..0 (DW=128, SE_MAX=128) -> next cycle win_valid=1, win_data=word, fullness=128, in_ready=1.
REQ-035 With fullness=128, consume 5 while accepting a word -> fullness=251, bits_used=5, window = old bits[122:0] followed by new word bits [127:123].
REQ-036 Accept a word with in_last, then consume 100 -> in_ready=0, win_valid=1 at fullness 28, win_data low 100 bits=0; consume 28 -> fullness=0, win_valid=0.
REQ-037 With bits_used=13, align_en -> 3 bits dropped, bits_used=16; then consume 200 (illegal) -> err=1 and fullness unchanged.
REQ-038 Assert start during simultaneous accept and consume -> all state 0 next cycle, err cleared, accept ignored.
REQ-039 Drive rstn low mid-stream (fullness=200, err=1) -> all outputs at reset values asynchronously, before the next clk edge.
